// File: rtl/pwm_pkg.sv
// Shared state encoding and register-bank layout for the two-channel PWM generator.
package pwm_pkg;

    localparam int unsigned REG_W   = 16;
    localparam int unsigned PER_LSB = 0;
    localparam int unsigned D0_LSB  = 16;
    localparam int unsigned D1_LSB  = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: a duty shadow reloaded at period boundaries and a registered compare.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CW = REG_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [CW-1:0] i_counter,
    input  logic          i_run,
    input  logic          i_load,
    input  logic [CW-1:0] i_duty,
    output logic          o_pwm
);

    logic [CW-1:0] r_duty_sh;
    logic          r_pwm;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_duty_sh <= '0;
            r_pwm     <= 1'b0;
        end else begin
            if (i_load) begin
                r_duty_sh <= i_duty;
            end
            // Compare uses the shadow in force this cycle, so a reload lands on counter 0.
            r_pwm <= i_run && (i_counter < r_duty_sh);
        end
    end

    assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_gen.sv
// Two-output PWM generator with a shared prescaler; register changes take effect at period wrap.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned CW       = REG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3*CW-1:0]   pwmRegs,
    output logic [1:0]        pwmOut,
    output logic              cycleStart,
    output logic              active,
    output logic [CW-1:0]     counter
);

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    pwm_state_e    r_state, w_state_next;
    logic [CW-1:0] r_per_sh;
    logic [CW-1:0] r_counter, w_counter_next;
    logic [15:0]   r_presc, w_presc_next;
    logic          r_cycle_start, w_cycle_start_next;
    logic          w_tick, w_wrap, w_load, w_run;
    logic [CW-1:0] w_new_per;

    assign w_new_per = pwmRegs[PER_LSB +: CW];
    assign w_tick    = (r_presc == PRESC_MAX);
    assign w_wrap    = w_tick && (r_counter == (r_per_sh - CW'(1)));
    assign w_run     = (r_state == RUN);

    always_comb begin
        w_state_next       = r_state;
        w_counter_next     = r_counter;
        w_presc_next       = r_presc;
        w_cycle_start_next = 1'b0;
        w_load             = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_counter_next = '0;
                w_presc_next   = '0;
                if (w_new_per != '0) begin
                    w_load             = 1'b1;
                    w_state_next       = RUN;
                    w_cycle_start_next = 1'b1;
                end
            end
            RUN: begin
                w_presc_next = w_tick ? 16'd0 : (r_presc + 16'd1);
                if (w_wrap) begin
                    w_counter_next = '0;
                    w_load         = 1'b1;
                    // A period of zero sampled at the wrap stops the generator cleanly.
                    if (w_new_per == '0) begin
                        w_state_next = IDLE;
                    end else begin
                        w_cycle_start_next = 1'b1;
                    end
                end else if (w_tick) begin
                    w_counter_next = r_counter + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_per_sh      <= '0;
            r_counter     <= '0;
            r_presc       <= '0;
            r_cycle_start <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_counter     <= w_counter_next;
            r_presc       <= w_presc_next;
            r_cycle_start <= w_cycle_start_next;
            if (w_load) begin
                r_per_sh <= w_new_per;
            end
        end
    end

    pwm_channel #(
        .CW (CW)
    ) u_ch0 (
        .clock     (clock),
        .reset     (reset),
        .i_counter (r_counter),
        .i_run     (w_run),
        .i_load    (w_load),
        .i_duty    (pwmRegs[D0_LSB +: CW]),
        .o_pwm     (pwmOut[0])
    );

    pwm_channel #(
        .CW (CW)
    ) u_ch1 (
        .clock     (clock),
        .reset     (reset),
        .i_counter (r_counter),
        .i_run     (w_run),
        .i_load    (w_load),
        .i_duty    (pwmRegs[D1_LSB +: CW]),
        .o_pwm     (pwmOut[1])
    );

    assign active     = w_run;
    assign cycleStart = r_cycle_start;
    assign counter    = r_counter;

endmodule

// File: tb/tb_pwm_gen.sv
// Scoreboard bench for pwm_gen: per-period length and high counts are queued and checked by monitors.
module tb_pwm_gen;

    typedef struct packed {
        int len;
        int h0;
        int h1;
    } period_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [47:0] regs1, regs4;
    logic [1:0]  pwm1, pwm4;
    logic        cs1, cs4, act1, act4;
    logic [15:0] cnt1, cnt4;

    int checks = 0;
    int errors = 0;
    int cs_cnt1 = 0;
    int cs_cnt4 = 0;
    period_t q1[$];
    period_t q4[$];

    always #5 clock = ~clock;

    pwm_gen #(.PRESCALE(1)) dut1 (
        .clock      (clock),
        .reset      (reset),
        .pwmRegs    (regs1),
        .pwmOut     (pwm1),
        .cycleStart (cs1),
        .active     (act1),
        .counter    (cnt1)
    );

    pwm_gen #(.PRESCALE(4)) dut4 (
        .clock      (clock),
        .reset      (reset),
        .pwmRegs    (regs4),
        .pwmOut     (pwm4),
        .cycleStart (cs4),
        .active     (act4),
        .counter    (cnt4)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_period(input string name, input int len, input int h0, input int h1,
                                input period_t exp);
        checks++;
        if (len != exp.len || h0 != exp.h0 || h1 != exp.h1) begin
            errors++;
            $display("FAIL %s: got len %0d h0 %0d h1 %0d, required len %0d h0 %0d h1 %0d",
                     name, len, h0, h1, exp.len, exp.h0, exp.h1);
        end
    endtask

    task automatic push(input int which, input int n, input int len, input int h0, input int h1);
        period_t p;
        p.len = len;
        p.h0  = h0;
        p.h1  = h1;
        repeat (n) begin
            if (which == 1) q1.push_back(p);
            else q4.push_back(p);
        end
    endtask

    task automatic wait_cs(input int which, input int target, input int budget);
        bit ok = 1'b0;
        int got = 0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clock);
            got = (which == 1) ? cs_cnt1 : cs_cnt4;
            if (got >= target) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_cs dut%0d: reached %0d cycleStarts, required %0d", which, got, target);
        end
    endtask

    task automatic wait_cnt1(input int value, input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clock);
            if (int'(cnt1) == value) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_cnt1: counter %0d, required %0d", cnt1, value);
        end
    endtask

    // Monitor for dut1: a period is complete when the next cycleStart arrives.
    int len1, h01, h11;
    bit prev1 = 1'b0;
    always @(negedge clock) begin
        if (reset || !act1) begin
            prev1 = 1'b0;
        end else begin
            len1++;
            h01 += int'(pwm1[0]);
            h11 += int'(pwm1[1]);
            if (cs1) begin
                cs_cnt1++;
                if (prev1) begin
                    if (q1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut1 unexpected period: len %0d h0 %0d h1 %0d, required none",
                                 len1, h01, h11);
                    end else begin
                        check_period("dut1 period", len1, h01, h11, q1.pop_front());
                    end
                end
                prev1 = 1'b1;
                len1  = 0;
                h01   = 0;
                h11   = 0;
            end
        end
    end

    int len4, h04, h14;
    bit prev4 = 1'b0;
    always @(negedge clock) begin
        if (reset || !act4) begin
            prev4 = 1'b0;
        end else begin
            len4++;
            h04 += int'(pwm4[0]);
            h14 += int'(pwm4[1]);
            if (cs4) begin
                cs_cnt4++;
                if (prev4) begin
                    if (q4.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dut4 unexpected period: len %0d h0 %0d h1 %0d, required none",
                                 len4, h04, h14);
                    end else begin
                        check_period("dut4 period", len4, h04, h14, q4.pop_front());
                    end
                end
                prev4 = 1'b1;
                len4  = 0;
                h04   = 0;
                h14   = 0;
            end
        end
    end

    initial begin
        int bad;
        int base;
        int n;
        reset = 1'b1;
        regs1 = '0;
        regs4 = '0;
        repeat (3) @(negedge clock);
        check("reset pwmOut", int'(pwm1), 0);
        check("reset active", int'(act1), 0);
        check("reset cycleStart", int'(cs1), 0);
        check("reset counter", int'(cnt1), 0);
        check("reset dut4 outputs", int'({pwm4, cs4, act4, cnt4}), 0);
        reset = 1'b0;

        // Idle with a zero period
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (pwm1 != 2'b00 || act1 || cs1) bad++;
        end
        check("idle bad cycles", bad, 0);

        // Start-up and basic waveform P=10 D0=3 D1=7
        base  = cs_cnt1;
        regs1 = {16'd7, 16'd3, 16'd10};
        push(1, 3, 10, 3, 7);
        @(negedge clock);
        check("startup active", int'(act1), 1);
        check("startup cycleStart", int'(cs1), 1);
        check("startup counter", int'(cnt1), 0);
        check("startup pwmOut before first edge", int'(pwm1), 0);
        @(negedge clock);
        check("startup first pwmOut", int'(pwm1), 3);
        check("startup cycleStart single", int'(cs1), 0);
        wait_cs(1, base + 4, 100);

        // Mid-period duty change waits for the wrap
        wait_cnt1(5, 20);
        regs1[31:16] = 16'd8;
        base = cs_cnt1;
        push(1, 1, 10, 3, 7);
        push(1, 1, 10, 8, 7);
        wait_cs(1, base + 2, 60);

        // Extreme duties: D0=0, D1=0xFFFF
        @(negedge clock);
        regs1 = {16'hFFFF, 16'd0, 16'd10};
        base  = cs_cnt1;
        push(1, 1, 10, 8, 7);
        push(1, 5, 10, 0, 10);
        wait_cs(1, base + 6, 150);

        // Stop: P=0 written at counter 3 finishes the period
        wait_cnt1(3, 20);
        regs1[15:0] = 16'd0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            n++;
            if (!act1) break;
        end
        check("stop cycles to idle", n, 7);
        check("stop counter", int'(cnt1), 0);
        check("stop cycleStart", int'(cs1), 0);
        check("stop last run pwmOut", int'(pwm1), 2);
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (pwm1 != 2'b00 || act1 || cs1) bad++;
        end
        check("after stop bad cycles", bad, 0);

        // P=1: every tick is a wrap, counter stays 0
        regs1 = {16'd0, 16'd1, 16'd1};
        push(1, 4, 1, 1, 0);
        bad = 0;
        repeat (5) begin
            @(negedge clock);
            if (cnt1 != 16'd0 || !cs1) bad++;
        end
        check("P=1 counter/cycleStart bad cycles", bad, 0);
        regs1 = '0;
        @(negedge clock);
        check("P=1 stop active", int'(act1), 0);

        // Restart, then reset mid-period
        regs1 = {16'd7, 16'd3, 16'd10};
        base  = cs_cnt1;
        push(1, 1, 10, 3, 7);
        wait_cs(1, base + 2, 60);
        wait_cnt1(4, 20);
        check("pre-reset active", int'(act1), 1);
        check("pre-reset pwmOut", int'(pwm1), 2);
        reset = 1'b1;
        #1;
        check("async reset pwmOut", int'(pwm1), 0);
        check("async reset active", int'(act1), 0);
        check("async reset cycleStart", int'(cs1), 0);
        check("async reset counter", int'(cnt1), 0);
        @(negedge clock);
        regs1 = '0;
        reset = 1'b0;

        // Prescaler 4: P=2 D0=1 D1=2
        regs4 = {16'd2, 16'd1, 16'd2};
        base  = cs_cnt4;
        push(4, 3, 8, 4, 8);
        bad = 0;
        wait_cs(4, base + 4, 100);
        check("dut4 counter in range", int'(cnt4 < 16'd2), 1);

        check("dut1 queue drained", q1.size(), 0);
        check("dut4 queue drained", q4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
